// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state encoding and accumulator sizing for matmul_core_p
package matmul_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_MAC,
        S_WR_C,
        S_DONE
    } mm_state_t;

    // Headroom of DIM_W bits lets dim_k products sum without wrapping.
    function automatic int acc_width(input int data_w, input int dim_w);
        return 2 * data_w + dim_w;
    endfunction

endpackage

// File: rtl/matmul_core_p_if.sv
// rtl/matmul_core_p_if.sv - single-port data memory bus between core and RAM
interface matmul_core_p_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_addr, output mem_we, output mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, input mem_we, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - unsigned multiply-accumulate with clear and enable
module mac_unit #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic              clock,
    input  logic              RST,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    acc_d, acc_q;

    always_comb begin
        prod  = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + {{(ACC_W-2*DATA_W){1'b0}}, prod};
        end
    end

    always_ff @(posedge clock) begin
        if (RST) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign acc = acc_q;
endmodule

// File: rtl/matmul_core_p.sv
// rtl/matmul_core_p.sv - hardwired C = A x B engine with row-interleaved multi-core split
module matmul_core_p
    import matmul_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int DIM_W   = 8,
    parameter int N_CORES = 1,
    parameter int CORE_ID = 0
) (
    input  logic               clock,
    input  logic               RST,
    input  logic               start,
    input  logic [DIM_W-1:0]   dim_i,
    input  logic [DIM_W-1:0]   dim_k,
    input  logic [DIM_W-1:0]   dim_j,
    input  logic [ADDR_W-1:0]  base_a,
    input  logic [ADDR_W-1:0]  base_b,
    input  logic [ADDR_W-1:0]  base_c,
    matmul_core_p_if.master    mem,
    output logic               busy,
    output logic               done,
    output logic               ovf
);
    localparam int ACC_W = acc_width(DATA_W, DIM_W);
    localparam int CW    = DIM_W + 1;
    localparam logic [CW-1:0] CORE_ID_C = CW'(CORE_ID);
    localparam logic [CW-1:0] N_CORES_C = CW'(N_CORES);

    mm_state_t           state_d, state_q;
    logic [DIM_W-1:0]    dim_i_d, dim_i_q, dim_k_d, dim_k_q, dim_j_d, dim_j_q;
    logic [CW-1:0]       i_d, i_q;
    logic [DIM_W-1:0]    j_d, j_q, k_d, k_q;
    logic [ADDR_W-1:0]   base_b_d, base_b_q;
    logic [ADDR_W-1:0]   pa_d, pa_q, row_a_d, row_a_q, stride_a_d, stride_a_q;
    logic [ADDR_W-1:0]   pb_d, pb_q, col_b_d, col_b_q;
    logic [ADDR_W-1:0]   pc_d, pc_q, row_c_d, row_c_q, stride_c_d, stride_c_q;
    logic [DATA_W-1:0]   a_d, a_q;
    logic                busy_d, busy_q, done_d, done_q, ovf_d, ovf_q;
    logic                mac_clr, mac_en;
    logic [ACC_W-1:0]    acc;
    logic [CW-1:0]       k_inc, j_inc, i_inc;

    mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clock (clock),
        .RST   (RST),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (a_q),
        .b     (mem.mem_rdata),
        .acc   (acc)
    );

    always_comb begin
        state_d = state_q;
        dim_i_d = dim_i_q;   dim_k_d = dim_k_q;   dim_j_d = dim_j_q;
        i_d = i_q;           j_d = j_q;           k_d = k_q;
        base_b_d = base_b_q;
        pa_d = pa_q;  row_a_d = row_a_q;  stride_a_d = stride_a_q;
        pb_d = pb_q;  col_b_d = col_b_q;
        pc_d = pc_q;  row_c_d = row_c_q;  stride_c_d = stride_c_q;
        a_d = a_q;
        ovf_d   = ovf_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        k_inc = {1'b0, k_q} + CW'(1);
        j_inc = {1'b0, j_q} + CW'(1);
        i_inc = i_q + N_CORES_C;

        case (state_q)
            S_IDLE: if (start) begin
                dim_i_d = dim_i;  dim_k_d = dim_k;  dim_j_d = dim_j;
                base_b_d = base_b;
                ovf_d = 1'b0;
                i_d = CORE_ID_C;  j_d = '0;  k_d = '0;
                mac_clr = 1'b1;
                // Constant-coefficient products only: seed and stride of the running pointers.
                row_a_d    = base_a + ADDR_W'(CORE_ID * int'(dim_k));
                pa_d       = base_a + ADDR_W'(CORE_ID * int'(dim_k));
                stride_a_d = ADDR_W'(N_CORES * int'(dim_k));
                pb_d       = base_b;
                col_b_d    = base_b;
                row_c_d    = base_c + ADDR_W'(CORE_ID * int'(dim_j));
                pc_d       = base_c + ADDR_W'(CORE_ID * int'(dim_j));
                stride_c_d = ADDR_W'(N_CORES * int'(dim_j));
                if (dim_i == '0 || dim_k == '0 || dim_j == '0 || CORE_ID_C >= {1'b0, dim_i})
                    state_d = S_DONE;
                else
                    state_d = S_RD_A;
            end
            S_RD_A: state_d = S_RD_B;
            S_RD_B: begin
                a_d = mem.mem_rdata;
                state_d = S_MAC;
            end
            S_MAC: begin
                mac_en = 1'b1;
                k_d  = k_inc[DIM_W-1:0];
                pa_d = pa_q + ADDR_W'(1);
                pb_d = pb_q + ADDR_W'(dim_j_q);
                state_d = (k_inc < {1'b0, dim_k_q}) ? S_RD_A : S_WR_C;
            end
            S_WR_C: begin
                mac_clr = 1'b1;
                k_d = '0;
                if (|acc[ACC_W-1:DATA_W]) ovf_d = 1'b1;
                if (j_inc == {1'b0, dim_j_q}) begin
                    j_d = '0;
                    i_d = i_inc;
                    pb_d = base_b_q;  col_b_d = base_b_q;
                    row_a_d = row_a_q + stride_a_q;  pa_d = row_a_q + stride_a_q;
                    row_c_d = row_c_q + stride_c_q;  pc_d = row_c_q + stride_c_q;
                    state_d = (i_inc >= {1'b0, dim_i_q}) ? S_DONE : S_RD_A;
                end else begin
                    j_d = j_inc[DIM_W-1:0];
                    pb_d = col_b_q + ADDR_W'(1);  col_b_d = col_b_q + ADDR_W'(1);
                    pa_d = row_a_q;
                    pc_d = pc_q + ADDR_W'(1);
                    state_d = S_RD_A;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (RST) begin
            state_q <= S_IDLE;
            dim_i_q <= '0;  dim_k_q <= '0;  dim_j_q <= '0;
            i_q <= '0;  j_q <= '0;  k_q <= '0;
            base_b_q <= '0;
            pa_q <= '0;  row_a_q <= '0;  stride_a_q <= '0;
            pb_q <= '0;  col_b_q <= '0;
            pc_q <= '0;  row_c_q <= '0;  stride_c_q <= '0;
            a_q <= '0;
            busy_q <= 1'b0;  done_q <= 1'b0;  ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dim_i_q <= dim_i_d;  dim_k_q <= dim_k_d;  dim_j_q <= dim_j_d;
            i_q <= i_d;  j_q <= j_d;  k_q <= k_d;
            base_b_q <= base_b_d;
            pa_q <= pa_d;  row_a_q <= row_a_d;  stride_a_q <= stride_a_d;
            pb_q <= pb_d;  col_b_q <= col_b_d;
            pc_q <= pc_d;  row_c_q <= row_c_d;  stride_c_q <= stride_c_d;
            a_q <= a_d;
            busy_q <= busy_d;  done_q <= done_d;  ovf_q <= ovf_d;
        end
    end

    // Memory bus is decoded from registered state only.
    always_comb begin
        mem.mem_addr  = '0;
        mem.mem_we    = 1'b0;
        mem.mem_wdata = '0;
        case (state_q)
            S_RD_A: mem.mem_addr = pa_q;
            S_RD_B: mem.mem_addr = pb_q;
            S_WR_C: begin
                mem.mem_addr  = pc_q;
                mem.mem_we    = 1'b1;
                mem.mem_wdata = acc[DATA_W-1:0];
            end
            default: ;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_matmul_core_p.sv
// tb/tb_matmul_core_p.sv - scoreboard bench for matmul_core_p (1-core, 2-core split, 8-bit)
module tb_matmul_core_p;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_v [3];
    logic [7:0]  di_v [3], dk_v [3], dj_v [3], ba_v [3], bb_v [3], bc_v [3];
    logic        busy_v [3], done_v [3], ovf_v [3], we_v [3];
    logic [7:0]  wa_v [3];
    logic [15:0] wd_v [3];
    logic [15:0] ram [3][256];

    typedef struct {
        int     g;
        int     addr;
        longint data;
    } wr_t;
    wr_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int DW = (g == 2) ? 8 : 16;
        matmul_core_p_if #(.ADDR_W(8), .DATA_W(DW)) bus ();
        matmul_core_p #(
            .DATA_W(DW), .ADDR_W(8), .DIM_W(8),
            .N_CORES((g == 1) ? 2 : 1), .CORE_ID((g == 1) ? 1 : 0)
        ) dut (
            .clock(clk), .RST(rst), .start(start_v[g]),
            .dim_i(di_v[g]), .dim_k(dk_v[g]), .dim_j(dj_v[g]),
            .base_a(ba_v[g]), .base_b(bb_v[g]), .base_c(bc_v[g]),
            .mem(bus), .busy(busy_v[g]), .done(done_v[g]), .ovf(ovf_v[g])
        );
        always @(posedge clk) bus.mem_rdata <= DW'(ram[g][bus.mem_addr]);
        assign we_v[g] = bus.mem_we;
        assign wa_v[g] = bus.mem_addr;
        assign wd_v[g] = 16'(bus.mem_wdata);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Write monitor: every DUT write must match the head of the expected queue.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (we_v[g] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: dut %0d addr %0d data %0d, expected none", g, wa_v[g], wd_v[g]);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_dut", g, e.g);
                    chk("wr_addr", wa_v[g], e.addr);
                    chk("wr_data", wd_v[g], e.data);
                end
            end
        end
    end

    task automatic load_fixed(input int g);
        for (int a = 0; a < 256; a++) ram[g][a] = 16'h0;
        ram[g][0] = 1;  ram[g][1] = 2;  ram[g][2] = 3;  ram[g][3] = 4;
        ram[g][16] = 5; ram[g][17] = 6; ram[g][18] = 7; ram[g][19] = 8;
    endtask

    // Runs one job on DUT g. fixed_done >= 0 overrides the formula-derived done cycle.
    task automatic run(input int g, input int ni, input int nk, input int nj,
                       input int ba, input int bb, input int bc,
                       input int disturb_at, input int rst_at, input int fixed_done);
        int id, nc, dw, e, c, busy_cnt, exp_cyc;
        longint mask, acc;
        bit eovf, got, zero;
        id = (g == 1) ? 1 : 0;
        nc = (g == 1) ? 2 : 1;
        dw = (g == 2) ? 8 : 16;
        mask = (longint'(1) << dw) - 1;
        zero = (ni == 0 || nk == 0 || nj == 0 || id >= ni);
        eovf = 0;
        e = 0;
        if (!zero) begin
            for (int i = id; i < ni; i += nc) begin
                for (int j = 0; j < nj; j++) begin
                    wr_t w;
                    acc = 0;
                    for (int k = 0; k < nk; k++)
                        acc += longint'(ram[g][(ba + i*nk + k) % 256] & 16'(mask)) *
                               longint'(ram[g][(bb + k*nj + j) % 256] & 16'(mask));
                    if (acc > mask) eovf = 1;
                    w.g = g;
                    w.addr = (bc + i*nj + j) % 256;
                    w.data = acc & mask;
                    if (rst_at < 0 || (e + 1) * (3*nk + 1) <= rst_at) exp_q.push_back(w);
                    e++;
                end
            end
        end
        exp_cyc = zero ? 1 : 1 + e * (3*nk + 1);
        if (fixed_done >= 0) exp_cyc = fixed_done;

        @(negedge clk);
        di_v[g] = 8'(ni); dk_v[g] = 8'(nk); dj_v[g] = 8'(nj);
        ba_v[g] = 8'(ba); bb_v[g] = 8'(bb); bc_v[g] = 8'(bc);
        start_v[g] = 1'b1;
        c = 0; busy_cnt = 0; got = 0;
        while (c < 3000 && !got) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                start_v[g] = 1'b0;
                chk("ovf_cleared_on_start", ovf_v[g], 0);
            end
            if (c == disturb_at) begin
                di_v[g] = 8'd3; dk_v[g] = 8'd1; dj_v[g] = 8'd4;
                ba_v[g] = 8'h55; bb_v[g] = 8'h66; bc_v[g] = 8'h77;
                start_v[g] = 1'b1;
            end
            if (c == disturb_at + 1) start_v[g] = 1'b0;
            if (busy_v[g]) busy_cnt++;
            if (c == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("rst_busy", busy_v[g], 0);
                chk("rst_we", we_v[g], 0);
                chk("rst_done", done_v[g], 0);
                rst = 1'b0;
                repeat (2) @(negedge clk);
                chk("rst_pending_writes", exp_q.size(), 0);
                return;
            end
            if (done_v[g]) got = 1;
        end
        chk("done_seen", got, 1);
        chk("done_cycle", c, exp_cyc);
        chk("busy_cycles", busy_cnt, exp_cyc);
        chk("ovf", ovf_v[g], eovf);
        @(negedge clk);
        chk("done_pulse_len", done_v[g], 0);
        chk("idle_after_done", busy_v[g], 0);
        chk("pending_writes", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            start_v[g] = 1'b0;
            di_v[g] = '0; dk_v[g] = '0; dj_v[g] = '0;
            ba_v[g] = '0; bb_v[g] = '0; bc_v[g] = '0;
            for (int a = 0; a < 256; a++) ram[g][a] = 16'h0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("reset_busy", busy_v[g], 0);
            chk("reset_done", done_v[g], 0);
            chk("reset_ovf", ovf_v[g], 0);
            chk("reset_we", we_v[g], 0);
        end
        rst = 1'b0;

        load_fixed(0);
        run(0, 2, 2, 2, 8'h00, 8'h10, 8'h20, -1, -1, 29);
        load_fixed(1);
        run(1, 2, 2, 2, 8'h00, 8'h10, 8'h20, -1, -1, 15);

        ram[2][0] = 200; ram[2][16] = 2;
        run(2, 1, 1, 1, 8'h00, 8'h10, 8'h20, -1, -1, -1);
        ram[2][0] = 3; ram[2][16] = 4;
        run(2, 1, 1, 1, 8'h00, 8'h10, 8'h20, -1, -1, -1);

        run(0, 2, 0, 2, 8'h00, 8'h10, 8'h20, -1, -1, 1);
        run(0, 2, 2, 2, 8'h00, 8'h10, 8'h20, 9, -1, 29);
        run(0, 2, 2, 2, 8'h00, 8'h10, 8'h20, -1, 10, -1);
        run(0, 2, 2, 2, 8'h00, 8'h10, 8'h20, -1, -1, 29);

        for (int t = 0; t < 12; t++) begin
            int g, ni, nk, nj, ba, bb, bc, dis, est;
            g  = int'($urandom_range(0, 2));
            ni = int'($urandom_range(0, 4));
            nk = int'($urandom_range(1, 4));
            nj = int'($urandom_range(1, 4));
            if (t == 5) nj = 0;
            ba = 32 + int'($urandom_range(0, 31));
            bb = 96 + int'($urandom_range(0, 31));
            bc = 192 + int'($urandom_range(0, 63));
            for (int a = 0; a < 256; a++)
                ram[g][a] = (t % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            est = ni * nj * (3*nk + 1) / ((g == 1) ? 2 : 1);
            dis = (est > 8) ? int'($urandom_range(2, 5)) : -1;
            run(g, ni, nk, nj, ba, bb, bc, dis, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
